// File: rtl/fpga_top.sv
// fpga_top: UART message beacon.
// Sends one 17-byte frame ("HELLO URP 2024\r\n" plus an XOR checksum byte)
// as 8N1 serial data on tx_data after reset. Status LEDs show busy, done,
// heartbeat and checksum-in-flight.
// Optional feature: define FPGA_TOP_LOOP_EN to resend the frame forever,
// with LOOP_GAP idle cycles between frames.
// clk_mem is present only for pin compatibility; nothing uses it.
module fpga_top #(
  parameter int CLKS_PER_BIT     = 868,
  parameter int START_DELAY      = 16,
  parameter int HEARTBEAT_CYCLES = 50_000_000,
  parameter int LOOP_GAP         = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_mem,
  output logic       tx_data,
  output logic [3:0] test_led
);

  localparam int BIT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int DLY_W = (START_DELAY > 0) ? $clog2(START_DELAY + 1) : 1;
  localparam int HB_W  = (HEARTBEAT_CYCLES > 1) ? $clog2(HEARTBEAT_CYCLES) : 1;

  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(CLKS_PER_BIT - 1);
  localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(START_DELAY);
  localparam logic [HB_W-1:0]  HB_LAST  = HB_W'(HEARTBEAT_CYCLES - 1);
  localparam logic [4:0]       CHK_IDX  = 5'd16;

  typedef enum logic [2:0] {
    WAIT,
    START,
    DATA,
    STOP,
    DONE
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [DLY_W-1:0] delay_cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic [2:0]       bit_idx;
  logic [4:0]       byte_idx;
  logic             done_flag;
  logic [HB_W-1:0]  hb_cnt;
  logic             hb_led;
  logic             busy;
  logic             bit_end;
  logic             chk_active;
  logic [7:0]       cur_byte;

`ifdef FPGA_TOP_LOOP_EN
  localparam int GAP_W = (LOOP_GAP > 1) ? $clog2(LOOP_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(LOOP_GAP - 1);
  logic [GAP_W-1:0] gap_cnt;
`else
  localparam int unused_loop_gap = LOOP_GAP;
`endif

  // Pin-compatibility input, deliberately left unconnected to any logic.
  logic unused_clk_mem;
  assign unused_clk_mem = clk_mem;

  // Message ROM; index 16 is the checksum (XOR of bytes 0..15).
  function automatic logic [7:0] frame_byte(input logic [4:0] idx);
    case (idx)
      5'd0:    frame_byte = 8'h48;
      5'd1:    frame_byte = 8'h45;
      5'd2:    frame_byte = 8'h4C;
      5'd3:    frame_byte = 8'h4C;
      5'd4:    frame_byte = 8'h4F;
      5'd5:    frame_byte = 8'h20;
      5'd6:    frame_byte = 8'h55;
      5'd7:    frame_byte = 8'h52;
      5'd8:    frame_byte = 8'h50;
      5'd9:    frame_byte = 8'h20;
      5'd10:   frame_byte = 8'h32;
      5'd11:   frame_byte = 8'h30;
      5'd12:   frame_byte = 8'h32;
      5'd13:   frame_byte = 8'h34;
      5'd14:   frame_byte = 8'h0D;
      5'd15:   frame_byte = 8'h0A;
      default: frame_byte = 8'h16;
    endcase
  endfunction

  // Next-state decode and line/LED outputs from the current state.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a value unassigned and no latch is inferred.
    state_next = state;
    busy       = 1'b0;
    tx_data    = 1'b1;
    cur_byte   = frame_byte(byte_idx);
    bit_end    = (bit_cnt == BIT_LAST);
    case (state)
      WAIT: begin
        if (delay_cnt == DLY_LAST) state_next = START;
      end
      START: begin
        busy    = 1'b1;
        tx_data = 1'b0;
        if (bit_end) state_next = DATA;
      end
      DATA: begin
        busy    = 1'b1;
        tx_data = cur_byte[bit_idx];
        if (bit_end && (bit_idx == 3'd7)) state_next = STOP;
      end
      STOP: begin
        busy = 1'b1;
        if (bit_end) state_next = (byte_idx == CHK_IDX) ? DONE : START;
      end
      DONE: begin
`ifdef FPGA_TOP_LOOP_EN
        if (gap_cnt == GAP_LAST) state_next = START;
`endif
      end
      default: state_next = WAIT;
    endcase
    chk_active = busy && (byte_idx == CHK_IDX);
  end

  assign test_led = {chk_active, hb_led, done_flag, busy};

  // State register plus bit/byte/delay counters for the transmitter.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples values from before this edge.
    if (rst) begin
      state     <= WAIT;
      delay_cnt <= '0;
      bit_cnt   <= '0;
      bit_idx   <= '0;
      byte_idx  <= '0;
      done_flag <= 1'b0;
`ifdef FPGA_TOP_LOOP_EN
      gap_cnt   <= '0;
`endif
    end else begin
      state <= state_next;

      if ((state == WAIT) && (state_next == WAIT)) delay_cnt <= delay_cnt + 1'b1;

      if (busy) bit_cnt <= bit_end ? '0 : bit_cnt + 1'b1;
      else      bit_cnt <= '0;

      if ((state == DATA) && bit_end) bit_idx <= bit_idx + 1'b1;

      if ((state == STOP) && bit_end && (byte_idx != CHK_IDX)) byte_idx <= byte_idx + 1'b1;

      if (state_next == DONE) done_flag <= 1'b1;

`ifdef FPGA_TOP_LOOP_EN
      if ((state == DONE) && (state_next == DONE)) gap_cnt <= gap_cnt + 1'b1;
      else                                         gap_cnt <= '0;
      if ((state == DONE) && (state_next == START)) byte_idx <= '0;
`endif
    end
  end

  // Free-running heartbeat, independent of the transmitter.
  always_ff @(posedge clk) begin
    if (rst) begin
      hb_cnt <= '0;
      hb_led <= 1'b0;
    end else if (hb_cnt == HB_LAST) begin
      hb_cnt <= '0;
      hb_led <= ~hb_led;
    end else begin
      hb_cnt <= hb_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fpga_top.sv
// tb_fpga_top: scoreboard bench for fpga_top with a small UART period.
// Expected frame bytes are queued on reset release and popped by a
// bit-centre UART monitor. A second instance with a toggling clk_mem must
// match the first one cycle for cycle.
module tb_fpga_top;

  localparam int CPB   = 4;
  localparam int DLY   = 16;
  localparam int HB    = 100;
  localparam int GAP   = 64;
  localparam int FRAME = 170 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clk_mem_a = 1'b0;
  logic       clk_mem_b = 1'b0;
  logic       tx_a, tx_b;
  logic [3:0] led_a, led_b;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] sb[$];
  logic [7:0] msg [16] = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h20, 8'h55, 8'h52,
                           8'h50, 8'h20, 8'h32, 8'h30, 8'h32, 8'h34, 8'h0D, 8'h0A};

  fpga_top #(.CLKS_PER_BIT(CPB), .START_DELAY(DLY), .HEARTBEAT_CYCLES(HB), .LOOP_GAP(GAP))
    dut_a (.clk(clk), .rst(rst), .clk_mem(clk_mem_a), .tx_data(tx_a), .test_led(led_a));

  fpga_top #(.CLKS_PER_BIT(CPB), .START_DELAY(DLY), .HEARTBEAT_CYCLES(HB), .LOOP_GAP(GAP))
    dut_b (.clk(clk), .rst(rst), .clk_mem(clk_mem_b), .tx_data(tx_b), .test_led(led_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // clk_mem of instance b wanders at random; instance a holds it at 0.
  always begin
    #($urandom_range(1, 13));
    clk_mem_b = ~clk_mem_b;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Expected frame: 16 message bytes, then their XOR.
  task automatic push_frame();
    logic [7:0] x = 8'h00;
    for (int i = 0; i < 16; i++) begin
      sb.push_back(msg[i]);
      x ^= msg[i];
    end
    sb.push_back(x);
  endtask

  // Monitor state
  logic       mon_active = 1'b0;
  int         mon_phase  = 0;
  logic       start_ok   = 1'b0;
  logic [7:0] mon_byte   = 8'h00;
  logic       prev_tx    = 1'b1;
  logic [3:0] prev_led   = 4'h0;
  int         led3_cnt = 0, led3_last = 0, led3_rise_cyc = 0;
  int         done_rise_cyc = 0, busy_fall_cyc = 0, frames_done = 0;
  logic       hb_seen = 1'b0;
  int         hb_last = 0;

  // UART decoder and LED event recorder, sampled on the falling edge.
  always @(negedge clk) begin
    check("clk_mem_indep", {27'd0, tx_b, led_b}, {27'd0, tx_a, led_a});
    if (rst) begin
      mon_active = 1'b0;
      hb_seen    = 1'b0;
      led3_cnt   = 0;
    end else begin
      if (mon_active) begin
        mon_phase++;
        if ((mon_phase % CPB) == (CPB / 2)) begin
          if (mon_phase / CPB == 0) start_ok = (tx_a == 1'b0);
          else if (mon_phase / CPB <= 8) mon_byte[mon_phase / CPB - 1] = tx_a;
          else begin
            check("framing", {30'd0, start_ok, tx_a}, 32'd3);
            if (sb.size() == 0) check("sb_underflow", 32'd1, 32'd0);
            else check("rx_byte", {24'd0, mon_byte}, {24'd0, sb.pop_front()});
            mon_active = 1'b0;
          end
        end
      end else if (!tx_a && prev_tx) begin
        mon_active = 1'b1;
        mon_phase  = 0;
      end

      if (led_a[3]) led3_cnt++;
      if (led_a[3] && !prev_led[3]) led3_rise_cyc = cyc;
      if (!led_a[3] && prev_led[3]) begin
        led3_last = led3_cnt;
        led3_cnt  = 0;
      end
      if (led_a[1] && !prev_led[1]) done_rise_cyc = cyc;
      if (!led_a[0] && prev_led[0]) begin
        busy_fall_cyc = cyc;
        frames_done++;
      end
      if (led_a[2] != prev_led[2]) begin
        if (hb_seen) check("hb_period", cyc - hb_last, HB);
        hb_seen = 1'b1;
        hb_last = cyc;
      end
    end
    prev_tx  = tx_a;
    prev_led = led_a;
  end

  task automatic wait_fall(output int t);
    t = -1;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (!tx_a) begin
        t = cyc;
        return;
      end
    end
    check("start_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_frame();
    int target = frames_done + 1;
    for (int k = 0; k < 2 * FRAME; k++) begin
      @(negedge clk);
      if (frames_done >= target) return;
    end
    check("frame_timeout", 32'd0, 32'd1);
  endtask

  // Release reset at a known point; returns the cycle count at release.
  task automatic release_rst(output int rel);
    #2 rst = 1'b0;
    rel = cyc;
    push_frame();
  endtask

  task automatic check_frame(input string tag, input int fall, input logic fresh);
    check({tag, "_len"}, busy_fall_cyc - fall, FRAME);
    check({tag, "_led3_len"}, led3_last, 10 * CPB);
    check({tag, "_led3_rise"}, led3_rise_cyc - fall, 16 * 10 * CPB);
    if (fresh) check({tag, "_done_with_busy"}, done_rise_cyc, busy_fall_cyc);
    check({tag, "_sb_empty"}, sb.size(), 0);
    check({tag, "_led_done"}, {30'd0, led_a[1:0]}, 32'd2);
  endtask

  initial begin
    int rel, fall, fall2, target;
    logic tx_ok, led1_ok;

    // Reset held for 20 cycles.
    @(negedge clk);
    check("rst_tx", tx_a, 1);
    check("rst_led", led_a, 0);
    repeat (19) @(negedge clk);
    check("rst_tx_end", tx_a, 1);
    check("rst_led_end", led_a, 0);

    release_rst(rel);
    wait_fall(fall);
    check("start_delay", fall - (rel + 1), DLY);
    wait_frame();
    check_frame("f1", fall, 1'b1);

`ifdef FPGA_TOP_LOOP_EN
    push_frame();
    wait_fall(fall2);
    check("loop_gap", fall2 - busy_fall_cyc, GAP);
    wait_frame();
    check_frame("f2", fall2, 1'b0);
`else
    tx_ok   = 1'b1;
    led1_ok = 1'b1;
    repeat (2000) begin
      @(negedge clk);
      if (tx_a !== 1'b1) tx_ok = 1'b0;
      if (led_a[1] !== 1'b1) led1_ok = 1'b0;
    end
    check("idle_tx_high", tx_ok, 1);
    check("done_held", led1_ok, 1);
`endif

    // Clean one-cycle reset, then abort mid-way through byte 5's data bits.
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    check("rst2_led", led_a, 0);
    release_rst(rel);
    wait_fall(fall);
    check("start_delay2", fall - (rel + 1), DLY);
    target = fall + 5 * 10 * CPB + CPB + 2 * CPB;
    while (cyc < target) @(negedge clk);
    check("pre_abort_tx", tx_a, 0);
    #2 rst = 1'b1;
    sb.delete();
    @(negedge clk);
    check("abort_tx", tx_a, 1);
    check("abort_led", led_a, 0);
    release_rst(rel);
    wait_fall(fall);
    check("start_delay3", fall - (rel + 1), DLY);
    wait_frame();
    check_frame("f3", fall, 1'b1);

    // Park in reset so a looping build stops producing bytes.
    @(negedge clk);
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
